pr_decoder: RTL and testbench
=============================

Name: pr_decoder

Overview:
- Sequential inverse of pr_coder: rebuilds the N-bit request vector from the stream of priority indices that a serial priority coder produces.
- pr_coder peels the highest set bit on each pass, so a legal frame is a strictly decreasing index sequence.
- Collects one index per handshake beat and sets the matching bit.
- On the beat marked last, presents the rebuilt mask, the beat count and an ordering-error flag through a valid/ready output. Sits downstream of pr_coder on the request path.

Parameters:
N, 8, width of rebuilt mask (number of request lines)
IW, 3, index width; must equal ceil(log2(N))
CW, 4, beat-counter width; must be at least ceil(log2(N+1))

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  index beat valid
in_ready  out  1  decoder accepts a beat
in_idx  in  IW  bit index from priority coder
in_last  in  1  final beat of frame
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_mask  out  N  rebuilt vector
out_cnt  out  CW  beats in frame (saturating)
out_err  out  1  ordering/range violation in frame

Behaviour:
- Reset (async, rst_n=0):
  - state=ACC; in_ready=1; out_valid=0.
  - out_mask=0, out_cnt=0, out_err=0.
  - Internal acc_mask=0, acc_cnt=0, acc_err=0, prev_idx=0.
  - Asserting reset mid-frame discards the partial frame. No output is produced for it.
- Beat acceptance: a beat is accepted on a rising edge with in_valid=1 and in_ready=1. Nothing happens otherwise.
- State ACC (in_ready=1, out_valid=0), per accepted beat:
  - in_idx<N: acc_mask bit in_idx is set.
  - in_idx>=N: no mask bit is set and the error flag is set. This case cannot occur when N=2^IW.
  - Error flag is also set when acc_cnt!=0 and in_idx>=prev_idx. This covers duplicates and increasing order.
  - acc_cnt increments, saturating at 2^CW-1.
  - prev_idx<=in_idx.
- Last beat (in_last=1) in ACC:
  - On the same edge, the updated values (including this beat) load out_mask, out_cnt and out_err.
  - out_valid goes 1, state goes to OUT and in_ready goes 0.
  - Latency: result is visible the cycle after the last beat's accepting edge.
- State OUT (in_ready=0, out_valid=1):
  - out_mask, out_cnt and out_err are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid goes 0, acc_* and prev_idx clear, state goes to ACC, in_ready goes 1.
  - In_valid is ignored during the handshake cycle. Minimum frame spacing is one bubble cycle.
- Output hold: out_mask, out_cnt and out_err keep their last values after the handshake until the next load. Consumers qualify them with out_valid.
- Single-beat frame (first beat has in_last=1): out_cnt=1, out_err=0, mask is one-hot.
- in_ready and out_valid are registered state decodes. There is no combinational path from in_* or out_ready to any output.

Test Plan:
- Reset then beats 7,4,0 (last on 0) -> out_mask=8'b1001_0001, out_cnt=3, out_err=0, out_valid high the cycle after beat 0, in_ready=0.
- Single beat idx=5 with last, out_ready=0 for 10 cycles -> out_mask=8'b0010_0000, out_cnt=1, all outputs stable for 10 cycles; then out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
- Beats 3,3 (duplicate) then 6 with last -> out_mask=8'b0100_1000, out_cnt=3, out_err=1.
- Full frame 7..0 descending, then a new frame beat 2 with last -> first result mask=8'hFF, cnt=8, err=0; second result mask=8'h04, cnt=1, err=0 (state cleared between frames).
- Beats 6,1 then assert rst_n=0 for 1 cycle -> outputs zero, in_ready=1; next frame beat 0 with last -> mask=8'h01, cnt=1, err=0.
- Random: beats taken from pr_coder output for 50 random num values (peel highest bit, clear it, repeat) -> out_mask==num for nonzero num, out_cnt==popcount(num), out_err=0; in_valid toggled randomly to check stalls.

Source files
------------

// File: rtl/pr_decoder.sv
// Serial priority decoder: rebuilds an N-bit request mask from the strictly
// decreasing index stream produced by pr_coder, one index per handshake beat.
module pr_decoder #(
    parameter int N  = 8,
    parameter int IW = 3,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_idx,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_mask,
    output logic [CW-1:0] out_cnt,
    output logic          out_err
);

    typedef enum logic {S_ACC, S_OUT} state_t;

    state_t        state, state_d;
    logic [N-1:0]  acc_mask, nxt_mask, set_mask;
    logic [CW-1:0] acc_cnt, nxt_cnt;
    logic          acc_err, nxt_err;
    logic [IW-1:0] prev_idx;
    logic          idx_ok, beat;

    // Out-of-range indices only exist when N is not a power of two.
    generate
        if (N == (1 << IW)) begin : g_full
            assign idx_ok = 1'b1;
        end else begin : g_part
            assign idx_ok = (32'(in_idx) < N);
        end
    endgenerate

    assign in_ready  = (state == S_ACC);
    assign out_valid = (state == S_OUT);
    assign beat      = in_valid && (state == S_ACC);

    always_comb begin
        set_mask = '0;
        if (idx_ok) set_mask[in_idx] = 1'b1;
        nxt_mask = acc_mask | set_mask;
        // Any non-decreasing step breaks the peel-highest-first ordering.
        nxt_err  = acc_err | !idx_ok | ((acc_cnt != '0) && (in_idx >= prev_idx));
        nxt_cnt  = (&acc_cnt) ? acc_cnt : acc_cnt + CW'(1);
    end

    always_comb begin
        state_d = state;
        case (state)
            S_ACC: if (beat && in_last) state_d = S_OUT;
            S_OUT: if (out_ready)       state_d = S_ACC;
            default:                    state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_ACC;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_mask <= '0;
            acc_cnt  <= '0;
            acc_err  <= 1'b0;
            prev_idx <= '0;
            out_mask <= '0;
            out_cnt  <= '0;
            out_err  <= 1'b0;
        end else if (beat) begin
            acc_mask <= nxt_mask;
            acc_cnt  <= nxt_cnt;
            acc_err  <= nxt_err;
            prev_idx <= in_idx;
            if (in_last) begin
                out_mask <= nxt_mask;
                out_cnt  <= nxt_cnt;
                out_err  <= nxt_err;
            end
        end else if (state == S_OUT && out_ready) begin
            acc_mask <= '0;
            acc_cnt  <= '0;
            acc_err  <= 1'b0;
            prev_idx <= '0;
        end
    end

endmodule

// File: tb/tb_pr_decoder.sv
// Bench for pr_decoder: directed frames push expected results into a
// scoreboard queue; a negedge monitor pops and compares each new result.
module tb_pr_decoder;

    localparam int N = 8, IW = 3, CW = 4;

    typedef struct packed {
        logic [N-1:0]  mask;
        logic [CW-1:0] cnt;
        logic          err;
    } res_t;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic [IW-1:0] in_idx = '0;
    logic          out_valid, out_ready = 1'b1, out_err;
    logic [N-1:0]  out_mask;
    logic [CW-1:0] out_cnt;

    int   checks = 0, errors = 0;
    res_t sb[$];
    res_t held;
    logic prev_v = 1'b0;

    pr_decoder #(.N(N), .IW(IW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mask(out_mask), .out_cnt(out_cnt), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop on each rising out_valid, then require the result to hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v <= 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    chk("out_mask", 32'(out_mask), 32'(e.mask));
                    chk("out_cnt",  32'(out_cnt),  32'(e.cnt));
                    chk("out_err",  32'(out_err),  32'(e.err));
                    held <= e;
                end
            end else if (out_valid && prev_v) begin
                chk("hold_mask", 32'(out_mask), 32'(held.mask));
                chk("hold_cnt",  32'(out_cnt),  32'(held.cnt));
                chk("hold_err",  32'(out_err),  32'(held.err));
            end
            prev_v <= out_valid;
        end
    end

    // Drive one beat; waits (bounded) for in_ready, returns #1 after acceptance.
    task automatic beat(input int idx, input bit last);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_idx   = IW'(idx);
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_res(input logic [N-1:0] m, input int c, input bit e);
        res_t r;
        r.mask = m;
        r.cnt  = CW'(c);
        r.err  = e;
        sb.push_back(r);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int num, cnt;
        #3;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_mask",  32'(out_mask),  32'd0);
        chk("rst_out_cnt",   32'(out_cnt),   32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // 7,4,0: check one-cycle latency and in_ready drop directly
        expect_res(8'b1001_0001, 3, 1'b0);
        out_ready = 1'b0;
        beat(7, 0); beat(4, 0); beat(0, 1);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_in_ready",  32'(in_ready),  32'd0);
        out_ready = 1'b1;
        idle(2);

        // single beat, held for 10 cycles under back-pressure
        expect_res(8'b0010_0000, 1, 1'b0);
        out_ready = 1'b0;
        beat(5, 1);
        idle(10);
        chk("held_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        idle(1);
        chk("hs_out_valid", 32'(out_valid), 32'd0);
        chk("hs_in_ready",  32'(in_ready),  32'd1);
        chk("hold_after_hs_mask", 32'(out_mask), 32'h20);

        // duplicate index
        expect_res(8'b0100_1000, 3, 1'b1);
        beat(3, 0); beat(3, 0); beat(6, 1);

        // full descending frame followed by a one-beat frame
        expect_res(8'hFF, 8, 1'b0);
        for (int i = 7; i >= 0; i--) beat(i, i == 0);
        expect_res(8'h04, 1, 1'b0);
        beat(2, 1);

        // counter saturation: 17 beats of the same index
        expect_res(8'h80, 15, 1'b1);
        for (int i = 0; i < 17; i++) beat(7, i == 16);
        idle(3);

        // reset mid-frame discards the partial frame
        beat(6, 0); beat(1, 0);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_mask",  32'(out_mask),  32'd0);
        chk("mrst_out_cnt",   32'(out_cnt),   32'd0);
        chk("mrst_out_err",   32'(out_err),   32'd0);
        chk("mrst_in_ready",  32'(in_ready),  32'd1);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        expect_res(8'h01, 1, 1'b0);
        beat(0, 1);
        idle(2);

        // pr_coder-style frames with random input bubbles
        for (int k = 0; k < 50; k++) begin
            num = $urandom_range(1, 255);
            cnt = $countones(num);
            expect_res(N'(num), cnt, 1'b0);
            for (int i = 7; i >= 0; i--) begin
                if (num[i]) begin
                    idle($urandom_range(0, 2));
                    beat(i, (num & ((1 << i) - 1)) == 0);
                end
            end
        end

        idle(5);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
